router_1x3: RTL and testbench
=============================

# router_1x3

Single-input, three-output packet router. It accepts byte-serial packets from one source port and steers each packet into one of three 16-entry output FIFOs according to the 2-bit address in the header byte. It checks an XOR parity byte on every packet and reports `error`. Each destination drains its FIFO with `read_enb_n`, and an unserviced FIFO is soft-reset after a 30-cycle timeout.

## Interface
- No parameters. Fixed values: FIFO depth 16, data width 8, timeout 30.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1 — rising-edge clock.
- `resetn` in 1 — asynchronous active-low reset.
- `pkt_valid` in 1 — high while header/payload bytes are on `data_in`; low in the cycle the parity byte is on `data_in`.
- `data_in` in 8 — packet byte.
- `busy` out 1 — source must hold `data_in`/`pkt_valid` unchanged while high.
- `error` out 1 — parity mismatch on the last packet.
- `read_enb_0/1/2` in 1 each — destination pop request.
- `valid_out_0/1/2` out 1 each — FIFO n not empty.
- `data_out_0/1/2` out 8 each — popped byte.

## Operation
- Packet format:
  - Header: `[7:2]` = payload length L (1..63), `[1:0]` = address (0..2).
  - Then L payload bytes.
  - Then the parity byte = XOR of the header and all payload bytes.
  - Address 3 is invalid: the header is ignored and the FSM stays in DECODE_ADDRESS.
- FIFOs: 16 × 8 each, independent read and write pointers, one write port fed by the FSM. Header, payload and parity are all stored, so a packet is L+2 entries.
- FSM states, transitions and `busy`:
  - DECODE_ADDRESS (`busy`=0):
    - `pkt_valid` high, valid address, target FIFO empty → LOAD_FIRST_DATA.
    - `pkt_valid` high, valid address, target FIFO not empty → WAIT_TILL_EMPTY.
    - The header is latched on entry.
  - WAIT_TILL_EMPTY (`busy`=1): → LOAD_FIRST_DATA when the target FIFO becomes empty.
  - LOAD_FIRST_DATA (`busy`=1): writes the latched header, starts parity = header → LOAD_DATA.
  - LOAD_DATA (`busy`=0):
    - `pkt_valid`=1: write `data_in` and XOR it into parity.
    - Target FIFO full: the byte is not written; latch it → FIFO_FULL_STATE.
    - `pkt_valid`=0: latch `data_in` as the received parity → LOAD_PARITY.
  - FIFO_FULL_STATE (`busy`=1): → LOAD_AFTER_FULL when not full.
  - LOAD_AFTER_FULL (`busy`=1): writes the held byte.
    - Byte was parity → CHECK_PARITY_ERROR.
    - Otherwise → LOAD_DATA.
  - LOAD_PARITY (`busy`=1): writes the parity byte, or goes to FIFO_FULL_STATE if full → CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR (`busy`=1): compares computed and received parity → DECODE_ADDRESS.
- `error`:
  - Registered; set in the cycle after CHECK_PARITY_ERROR on a mismatch, cleared on a match.
  - Holds its value until the next packet's check or reset.
  - The packet is delivered regardless of its parity.
- `valid_out_n` = !empty_n, combinational from the FIFO pointers.
- Read: `read_enb_n` high with FIFO n non-empty pops one entry; the byte is registered onto `data_out_n` at that edge. A read of an empty FIFO is ignored and `data_out_n` holds.
- Soft reset:
  - Per-FIFO counter increments each cycle `valid_out_n`=1 and `read_enb_n`=0; any read or empty FIFO clears it.
  - At count 30, FIFO n is flushed (pointers 0, `data_out_n`=0, counter 0).
  - If the FSM is writing that FIFO at that moment, it returns to DECODE_ADDRESS; the remaining source bytes are dropped until `pkt_valid` falls.

## Timing
- Reset (async, any time, including mid-packet):
  - FSM → DECODE_ADDRESS.
  - All FIFOs empty.
  - `busy`=0, `error`=0, `valid_out_*`=0, `data_out_*`=0.
  - Parity and soft-reset counters cleared.
- Header sampled at edge T0 (DECODE_ADDRESS, FIFO empty).
- Header written at T1 (LOAD_FIRST_DATA, `busy`=1); the source holds payload byte 1 through T1.
- `valid_out_n`=1 after T1.
- Payload byte k is written at T1+k, one byte per cycle when not full.
- Parity byte: presented with `pkt_valid`=0 at T1+L+1, written at T1+L+2; `error` valid after T1+L+3.
- A new header is accepted no earlier than the edge after CHECK_PARITY_ERROR.
- A read and a write on the same FIFO in the same cycle are both performed, even when full or empty with one entry present.
- Full = 16 entries: a write is blocked. Empty: a read is blocked. Pointers wrap modulo 16.

## Test plan
- Reset mid-packet (assert `resetn`=0 during LOAD_DATA) → all outputs 0, FIFOs empty, the next header is accepted normally.
- Header 8'h0D (L=3, addr 1), payload 01,02,03, parity 0D^01^02^03=0D → FIFO1 holds 0D,01,02,03,0D; `error`=0; `read_enb_1` pops them in order; `valid_out_1` falls after the 5th pop.
- Same packet with parity 8'hFF → `error`=1 after the check; the bytes are still delivered.
- Header L=20 to addr 2 with no reads → `busy` high on entry 16 (FIFO_FULL_STATE); a single read releases it; all 22 bytes arrive intact and in order.
- Packet to addr 0, then `valid_out_0` left unread for 30 cycles → FIFO0 flushed, `valid_out_0`=0, `data_out_0`=0.
- Second packet to addr 0 while FIFO0 is non-empty → `busy`=1 (WAIT_TILL_EMPTY) until all entries are read; the header is then written.

Source files
------------

// File: rtl/router_1x3.sv
// 1-to-3 byte-serial packet router: header-addressed steering into three
// 16x8 FIFOs, XOR parity check, and per-FIFO flush when a destination stalls.
module router_1x3 (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic       read_enb_0,
  input  logic       read_enb_1,
  input  logic       read_enb_2,
  output logic       busy,
  output logic       error,
  output logic       valid_out_0,
  output logic       valid_out_1,
  output logic       valid_out_2,
  output logic [7:0] data_out_0,
  output logic [7:0] data_out_1,
  output logic [7:0] data_out_2
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE,
    LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY
  } state_e;

  state_e     state_q;
  logic [7:0] hdr_q, par_q, prx_q, held_q;
  logic       held_par_q, drop_q, busy_q, error_q;

  logic [7:0] mem_q    [3][16];
  logic [4:0] wr_ptr_q [3];
  logic [4:0] rd_ptr_q [3];
  logic [4:0] tmo_q    [3];
  logic [7:0] dout_q   [3];

  logic [2:0] rd_en_s, empty_s, full_s, rd_fire_s, flush_s;
  logic [1:0] tgt_s;
  logic       wr_ok_s, we_s, abort_s, drop_abort_s;
  logic [7:0] wdata_s;

  // FIFO status, pops and stall-timeout flush requests
  always_comb begin
    rd_en_s = {read_enb_2, read_enb_1, read_enb_0};
    for (int i = 0; i < 3; i++) begin
      empty_s[i]   = (wr_ptr_q[i] == rd_ptr_q[i]);
      full_s[i]    = (wr_ptr_q[i] == {~rd_ptr_q[i][4], rd_ptr_q[i][3:0]});
      rd_fire_s[i] = rd_en_s[i] & ~empty_s[i];
      flush_s[i]   = ~empty_s[i] & ~rd_en_s[i] & (tmo_q[i] == 5'd29);
    end
  end

  // Write-port decode; a pop in the same cycle frees room for a write into a full FIFO
  always_comb begin
    tgt_s        = hdr_q[1:0];
    wr_ok_s      = ~full_s[tgt_s] | rd_fire_s[tgt_s];
    we_s         = 1'b0;
    wdata_s      = 8'h00;
    abort_s      = 1'b0;
    drop_abort_s = 1'b0;
    case (state_q)
      LOAD_FIRST_DATA: begin
        we_s         = 1'b1;
        wdata_s      = hdr_q;
        abort_s      = flush_s[tgt_s];
        drop_abort_s = 1'b1;
      end
      LOAD_DATA: begin
        we_s         = pkt_valid & wr_ok_s;
        wdata_s      = data_in;
        abort_s      = flush_s[tgt_s];
        drop_abort_s = pkt_valid;
      end
      LOAD_PARITY: begin
        we_s    = wr_ok_s;
        wdata_s = prx_q;
        abort_s = flush_s[tgt_s];
      end
      LOAD_AFTER_FULL: begin
        we_s         = 1'b1;
        wdata_s      = held_q;
        abort_s      = flush_s[tgt_s];
        drop_abort_s = ~held_par_q;
      end
      FIFO_FULL_STATE: begin
        abort_s      = flush_s[tgt_s];
        drop_abort_s = ~held_par_q;
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // FIFO storage, written only by the FSM
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (we_s && (tgt_s == 2'(i)) && !flush_s[i]) begin
        mem_q[i][wr_ptr_q[i][3:0]] <= wdata_s;
      end
    end
  end

  // FIFO pointers, registered read data and stall-timeout counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) begin
        wr_ptr_q[i] <= 5'd0;
        rd_ptr_q[i] <= 5'd0;
        tmo_q[i]    <= 5'd0;
        dout_q[i]   <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (flush_s[i]) begin
          wr_ptr_q[i] <= 5'd0;
          rd_ptr_q[i] <= 5'd0;
          tmo_q[i]    <= 5'd0;
          dout_q[i]   <= 8'h00;
        end else begin
          if (we_s && (tgt_s == 2'(i))) wr_ptr_q[i] <= wr_ptr_q[i] + 5'd1;
          if (rd_fire_s[i]) begin
            rd_ptr_q[i] <= rd_ptr_q[i] + 5'd1;
            dout_q[i]   <= mem_q[i][rd_ptr_q[i][3:0]];
          end
          if (empty_s[i] || rd_en_s[i]) tmo_q[i] <= 5'd0;
          else                          tmo_q[i] <= tmo_q[i] + 5'd1;
        end
      end
    end
  end

  // Packet FSM; drop_q discards the tail of a packet whose FIFO was flushed mid-write
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= DECODE_ADDRESS;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      hdr_q      <= 8'h00;
      par_q      <= 8'h00;
      prx_q      <= 8'h00;
      held_q     <= 8'h00;
      held_par_q <= 1'b0;
      drop_q     <= 1'b0;
    end else if (abort_s) begin
      state_q <= DECODE_ADDRESS;
      busy_q  <= 1'b0;
      drop_q  <= drop_abort_s;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (drop_q) begin
            if (!pkt_valid) drop_q <= 1'b0;
          end else if (pkt_valid && (data_in[1:0] != 2'b11)) begin
            hdr_q   <= data_in;
            busy_q  <= 1'b1;
            state_q <= empty_s[data_in[1:0]] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (empty_s[tgt_s]) state_q <= LOAD_FIRST_DATA;
        end
        LOAD_FIRST_DATA: begin
          par_q   <= hdr_q;
          busy_q  <= 1'b0;
          state_q <= LOAD_DATA;
        end
        LOAD_DATA: begin
          if (pkt_valid) begin
            if (wr_ok_s) begin
              par_q <= par_q ^ data_in;
            end else begin
              held_q     <= data_in;
              held_par_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= FIFO_FULL_STATE;
            end
          end else begin
            prx_q   <= data_in;
            busy_q  <= 1'b1;
            state_q <= LOAD_PARITY;
          end
        end
        FIFO_FULL_STATE: begin
          if (!full_s[tgt_s]) state_q <= LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (held_par_q) begin
            state_q <= CHECK_PARITY_ERROR;
          end else begin
            par_q   <= par_q ^ held_q;
            busy_q  <= 1'b0;
            state_q <= LOAD_DATA;
          end
        end
        LOAD_PARITY: begin
          if (wr_ok_s) begin
            state_q <= CHECK_PARITY_ERROR;
          end else begin
            held_q     <= prx_q;
            held_par_q <= 1'b1;
            state_q    <= FIFO_FULL_STATE;
          end
        end
        CHECK_PARITY_ERROR: begin
          error_q <= (par_q != prx_q);
          busy_q  <= 1'b0;
          state_q <= DECODE_ADDRESS;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= DECODE_ADDRESS;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign error       = error_q;
  assign valid_out_0 = ~empty_s[0];
  assign valid_out_1 = ~empty_s[1];
  assign valid_out_2 = ~empty_s[2];
  assign data_out_0  = dout_q[0];
  assign data_out_1  = dout_q[1];
  assign data_out_2  = dout_q[2];

endmodule

// File: tb/tb_router_1x3.sv
// Scoreboard bench for router_1x3: packets are queued per destination when sent,
// and a monitor pops and compares every byte the DUT delivers.
module tb_router_1x3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [2:0] rd_en = 3'b000;
  logic       busy, error;
  logic [2:0] vout;
  logic [7:0] d0, d1, d2;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q [3][$];
  int         pop_cnt [3];
  int         rd_mode [3];
  bit         pkt_done = 1'b0;

  router_1x3 dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .busy(busy), .error(error),
    .read_enb_0(rd_en[0]), .read_enb_1(rd_en[1]), .read_enb_2(rd_en[2]),
    .valid_out_0(vout[0]), .valid_out_1(vout[1]), .valid_out_2(vout[2]),
    .data_out_0(d0), .data_out_1(d1), .data_out_2(d2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dout_of(input int i);
    case (i)
      0:       return d0;
      1:       return d1;
      default: return d2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Destination readers: 0 = idle, 1 = random, 2 = always read
  initial begin
    for (int i = 0; i < 3; i++) begin rd_mode[i] = 0; pop_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        rd_en[i] = (rd_mode[i] == 0) ? 1'b0 : (rd_mode[i] == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: a pop is a read of a non-empty FIFO; compare the byte it registers
  initial begin
    logic [2:0] pend;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      #2;
      pend = rd_en & vout;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (pend[i]) begin
          pop_cnt[i]++;
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_pop%0d", i), 32'(dout_of(i)), 32'hFFFF_FFFF);
          end else begin
            exp = exp_q[i].pop_front();
            check($sformatf("data_out_%0d", i), 32'(dout_of(i)), 32'(exp));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic wait_not_busy();
    int n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic send_pkt(input logic [1:0] a, input int len, input logic [7:0] par_xor, input bit fixed);
    logic [7:0] b[$];
    logic [7:0] p;
    pkt_done = 1'b0;
    b.push_back({len[5:0], a});
    for (int k = 1; k <= len; k++) b.push_back(fixed ? 8'(k) : 8'($urandom));
    p = 8'h00;
    foreach (b[k]) p = p ^ b[k];
    b.push_back(p ^ par_xor);
    foreach (b[k]) exp_q[a].push_back(b[k]);
    for (int j = 0; j < b.size(); j++) begin
      @(negedge clk);
      pkt_valid = (j < b.size() - 1);
      data_in   = b[j];
      wait_not_busy();
    end
    @(negedge clk);
    wait_not_busy();
    check("error", 32'(error), 32'(par_xor != 8'h00));
    pkt_done = 1'b1;
  endtask

  task automatic send_bad_hdr();
    @(negedge clk);
    pkt_valid = 1'b1;
    data_in   = {6'($urandom_range(1, 63)), 2'b11};
    wait_not_busy();
    @(negedge clk);
    pkt_valid = 1'b0;
    check("addr3_ignored_busy", 32'(busy), 32'd0);
  endtask

  task automatic pulse_read(input int i);
    @(posedge clk);
    rd_mode[i] = 2;
    @(posedge clk);
    rd_mode[i] = 0;
  endtask

  task automatic wait_pkt_done();
    int n = 0;
    while (!pkt_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("pkt_timeout", 32'(pkt_done), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    for (int i = 0; i < 3; i++) rd_mode[i] = 2;
    while (vout != 3'b000 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    if (n >= 2000) check("drain_timeout", 32'(vout), 32'd0);
    for (int i = 0; i < 3; i++) rd_mode[i] = 0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_vout", 32'(vout), 32'd0);
    check("rst_d0", 32'(d0), 32'd0);
    check("rst_d1", 32'(d1), 32'd0);
    check("rst_d2", 32'(d2), 32'd0);
    resetn = 1'b1;

    // Good-parity packet 0D,01,02,03,0D to FIFO1
    send_pkt(2'd1, 3, 8'h00, 1'b1);
    check("vout1_loaded", 32'(vout[1]), 32'd1);
    pop_cnt[1] = 0;
    drain();
    check("fifo1_pops", 32'(pop_cnt[1]), 32'd5);
    check("fifo1_model_empty", 32'(exp_q[1].size()), 32'd0);

    // Same packet with parity FF: error set, bytes still delivered
    send_pkt(2'd1, 3, 8'hF2, 1'b1);
    drain();

    // Asynchronous reset in the middle of a packet
    @(negedge clk);
    pkt_valid = 1'b1;
    data_in   = {6'd5, 2'd2};
    repeat (3) begin
      @(negedge clk);
      data_in = 8'h11;
    end
    resetn = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_vout", 32'(vout), 32'd0);
    check("midrst_d1", 32'(d1), 32'd0);
    pkt_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // L=20 to FIFO2 with no reads: stalls once 16 entries are stored
    fork
      send_pkt(2'd2, 20, 8'h00, 1'b0);
    join_none
    repeat (15) @(negedge clk);
    check("full_not_yet_busy", 32'(busy), 32'd0);
    repeat (7) @(negedge clk);
    check("full_busy", 32'(busy), 32'd1);
    check("full_vout2", 32'(vout[2]), 32'd1);
    rd_mode[2] = 2;
    wait_pkt_done();
    drain();

    // Unserviced FIFO0 is flushed after 30 idle cycles
    send_pkt(2'd0, 2, 8'h00, 1'b0);
    pulse_read(0);
    repeat (20) @(negedge clk);
    check("flush_not_yet", 32'(vout[0]), 32'd1);
    repeat (15) @(negedge clk);
    check("flush_vout0", 32'(vout[0]), 32'd0);
    check("flush_d0", 32'(d0), 32'd0);
    exp_q[0].delete();

    // Second packet to a non-empty FIFO0 waits until it is drained
    send_pkt(2'd0, 3, 8'h00, 1'b0);
    fork
      send_pkt(2'd0, 2, 8'h00, 1'b0);
    join_none
    repeat (5) @(negedge clk);
    check("wait_empty_busy", 32'(busy), 32'd1);
    rd_mode[0] = 2;
    wait_pkt_done();
    drain();

    // Randomized traffic with random readers
    for (int i = 0; i < 3; i++) rd_mode[i] = 1;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0) send_bad_hdr();
      send_pkt(2'($urandom_range(0, 2)), int'($urandom_range(1, 20)),
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 1'b0);
    end
    drain();
    for (int i = 0; i < 3; i++)
      check($sformatf("model_empty%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
